// File: rtl/ram1_bus_arbiter_pkg.sv
// Shared types and address map for the RAM1/UART bus arbiter.
package ram1_bus_arbiter_pkg;

    localparam logic [15:0] Ram1UpperDflt  = 16'h8000;
    localparam logic [15:0] Com1DataDflt   = 16'hBF00;
    localparam logic [15:0] Com1CommandDfl = 16'hBF01;

    typedef enum logic [2:0] {
        StIdle,
        StRamRd,
        StRamWr,
        StUart,
        StStatRd,
        StDone
    } arb_state_e;

    typedef enum logic [2:0] {
        UsIdle,
        UsRd1,
        UsRd2,
        UsWr,
        UsWaitTbre,
        UsWaitTsre
    } uart_state_e;

endpackage

// File: rtl/ram1_bus_arbiter_uart_seq.sv
// COM1 access sequencer: two-cycle read strobe, one-cycle write strobe, then
// waits for the transmitter to drain. Started and acknowledged by the arbiter FSM.
module ram1_bus_arbiter_uart_seq
    import ram1_bus_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic write_i,
    input  logic tbre_i,
    input  logic tsre_i,
    output logic rdn_o,
    output logic wrn_o,
    output logic drive_o,
    output logic done_o
);

    uart_state_e state_q, state_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= UsIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdn_o   = 1'b1;
        wrn_o   = 1'b1;
        drive_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            UsIdle: begin
                if (start_i) begin
                    state_d = write_i ? UsWr : UsRd1;
                end
            end
            UsRd1: begin
                rdn_o   = 1'b0;
                state_d = UsRd2;
            end
            UsRd2: begin
                // The arbiter samples the received byte at the end of this cycle.
                rdn_o   = 1'b0;
                done_o  = 1'b1;
                state_d = UsIdle;
            end
            UsWr: begin
                wrn_o   = 1'b0;
                drive_o = 1'b1;
                state_d = UsWaitTbre;
            end
            UsWaitTbre: begin
                if (tbre_i) begin
                    state_d = UsWaitTsre;
                end
            end
            UsWaitTsre: begin
                if (tsre_i) begin
                    done_o  = 1'b1;
                    state_d = UsIdle;
                end
            end
            default: state_d = UsIdle;
        endcase
    end

endmodule

// File: rtl/ram1_bus_arbiter.sv
// Arbitrates the RAM1/UART bus between instruction fetch and data memory and
// sequences RAM1, COM1 data and COM1 status accesses.
module ram1_bus_arbiter
    import ram1_bus_arbiter_pkg::*;
#(
    parameter logic [15:0] RAM1_UPPER   = Ram1UpperDflt,
    parameter logic [15:0] COM1_DATA    = Com1DataDflt,
    parameter logic [15:0] COM1_COMMAND = Com1CommandDfl
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_data,
    output logic        if_ack,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] Address,
    input  logic [15:0] WriteData,
    output logic [15:0] ReadData,
    output logic        mem_ack,
    output logic        stall,
    inout  wire  [15:0] Ram1Data,
    output logic [17:0] Ram1Addr,
    output logic        Ram1EN,
    output logic        Ram1OE,
    output logic        Ram1WE,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre,
    output logic        rdn,
    output logic        wrn
);

    arb_state_e  state_q, state_d;
    logic        grant_mem_q, grant_mem_d;
    logic        wr_q, wr_d;
    logic        hold_q, hold_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] if_data_q, if_data_d;

    logic in_ram, is_cdata, is_cmd, mem_sel;
    logic uart_start, uart_drive, uart_done;
    logic bus_drive;

    assign in_ram   = Address < RAM1_UPPER;
    assign is_cdata = Address == COM1_DATA;
    assign is_cmd   = Address == COM1_COMMAND;
    assign mem_sel  = (MemRead | MemWrite) & (in_ram | is_cdata | is_cmd);

    ram1_bus_arbiter_uart_seq u_uart_seq (
        .clk     (clk),
        .rst     (rst),
        .start_i (uart_start),
        .write_i (MemWrite),
        .tbre_i  (tbre),
        .tsre_i  (tsre),
        .rdn_o   (rdn),
        .wrn_o   (wrn),
        .drive_o (uart_drive),
        .done_o  (uart_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_mem_q <= 1'b0;
            wr_q        <= 1'b0;
            hold_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            if_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_mem_q <= grant_mem_d;
            wr_q        <= wr_d;
            hold_q      <= hold_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            if_data_q   <= if_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_mem_d = grant_mem_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        if_data_d   = if_data_q;
        hold_d      = (state_q == StRamWr);
        uart_start  = 1'b0;
        bus_drive   = 1'b0;
        Ram1EN      = 1'b1;
        Ram1OE      = 1'b1;
        Ram1WE      = 1'b1;
        case (state_q)
            StIdle: begin
                // Data port always wins; a waiting fetch is retried next idle.
                if (mem_sel) begin
                    grant_mem_d = 1'b1;
                    wr_d        = MemWrite;
                    wdata_d     = WriteData;
                    if (in_ram) begin
                        addr_d  = Address;
                        state_d = MemWrite ? StRamWr : StRamRd;
                    end else if (is_cdata) begin
                        uart_start = 1'b1;
                        state_d    = StUart;
                    end else begin
                        state_d = StStatRd;
                    end
                end else if (if_req) begin
                    grant_mem_d = 1'b0;
                    wr_d        = 1'b0;
                    addr_d      = if_addr;
                    state_d     = StRamRd;
                end
            end
            StRamRd: begin
                Ram1EN = 1'b0;
                Ram1OE = 1'b0;
                if (grant_mem_q) begin
                    rdata_d = Ram1Data;
                end else begin
                    if_data_d = Ram1Data;
                end
                state_d = StDone;
            end
            StRamWr: begin
                Ram1EN    = 1'b0;
                Ram1WE    = 1'b0;
                bus_drive = 1'b1;
                state_d   = StDone;
            end
            StUart: begin
                if (uart_done) begin
                    if (!wr_q) begin
                        rdata_d = {8'h00, Ram1Data[7:0]};
                    end
                    state_d = StDone;
                end
            end
            StStatRd: begin
                if (!wr_q) begin
                    rdata_d = {14'b0, data_ready, tbre & tsre};
                end
                state_d = StDone;
            end
            StDone: begin
                // Keep write data on the bus one cycle past the WE rising edge.
                bus_drive = hold_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign Ram1Data = bus_drive  ? wdata_q :
                      uart_drive ? {8'h00, wdata_q[7:0]} : 16'hzzzz;
    assign Ram1Addr = {2'b00, addr_q};
    assign ReadData = rdata_q;
    assign if_data  = if_data_q;
    assign mem_ack  = (state_q == StDone) & grant_mem_q;
    assign if_ack   = (state_q == StDone) & ~grant_mem_q;
    assign stall    = mem_sel & ~mem_ack;

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Randomized bench for ram1_bus_arbiter with a RAM1/UART device model and a
// transaction-level reference for latency, strobes and returned data.
module tb_ram1_bus_arbiter;

    localparam int KFetch    = 0;
    localparam int KRamRd    = 1;
    localparam int KRamWr    = 2;
    localparam int KUartRd   = 3;
    localparam int KUartWr   = 4;
    localparam int KStatRd   = 5;
    localparam int KStatWr   = 6;
    localparam int KRam2     = 7;
    localparam int KConflict = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, MemRead, MemWrite, data_ready, tbre, tsre;
    logic [15:0] if_addr, Address, WriteData;
    logic [15:0] if_data, ReadData;
    logic        if_ack, mem_ack, stall;
    wire  [15:0] ram1_data;
    logic [17:0] ram1_addr;
    logic        ram1_en, ram1_oe, ram1_we, rdn, wrn;

    always #5 clk = ~clk;

    ram1_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_data    (if_data),
        .if_ack     (if_ack),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .Ram1Data   (ram1_data),
        .Ram1Addr   (ram1_addr),
        .Ram1EN     (ram1_en),
        .Ram1OE     (ram1_oe),
        .Ram1WE     (ram1_we),
        .data_ready (data_ready),
        .tbre       (tbre),
        .tsre       (tsre),
        .rdn        (rdn),
        .wrn        (wrn)
    );

    // Board-side devices: RAM1 array and a UART byte source/sink.
    logic [15:0] ram_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [7:0]  uart_rx;
    logic [7:0]  tx_q [$];
    int          oe_cnt, we_cnt, rdn_cnt, wrn_cnt;
    logic        dev_drv;
    logic [15:0] dev_val;

    assign dev_drv   = rst && ((!ram1_en && !ram1_oe) || !rdn);
    assign dev_val   = !rdn ? {8'hC3, uart_rx} : ram_mem[ram1_addr[14:0]];
    assign ram1_data = dev_drv ? dev_val : 16'hzzzz;

    always @(negedge clk) begin
        if (rst) begin
            if (!ram1_oe) oe_cnt = oe_cnt + 1;
            if (!ram1_we) begin
                we_cnt = we_cnt + 1;
                if (!ram1_en) ram_mem[ram1_addr[14:0]] = ram1_data;
            end
            if (!rdn) rdn_cnt = rdn_cnt + 1;
            if (!wrn) begin
                wrn_cnt = wrn_cnt + 1;
                tx_q.push_back(ram1_data[7:0]);
            end
        end
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] last_rd = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // One transaction from an idle cycle to the cycle after its last ack.
    task automatic do_xact(input int kind, input logic [15:0] addr, input logic [15:0] wd,
                           input logic [15:0] iaddr, input int b_rise, input int s_rise);
        int          mem_lat, if_lat, stalls, max_cyc, e_mem, e_if, tb_c, ts_c;
        int          e_oe, e_we, e_rdn, e_wrn;
        bit          want_mem, want_if, wr;
        logic [15:0] bus_at_ack;
        want_if  = (kind == KFetch) || (kind == KConflict);
        want_mem = (kind != KFetch);
        wr       = (kind == KRamWr) || (kind == KUartWr) || (kind == KStatWr) ||
                   ((kind == KRam2) && ($urandom_range(0, 1) == 1));
        e_mem = -1; e_if = -1; e_oe = 0; e_we = 0; e_rdn = 0; e_wrn = 0;
        case (kind)
            KFetch:    begin e_if = 2; e_oe = 1; end
            KRamRd:    begin e_mem = 2; e_oe = 1; last_rd = ref_mem[addr[14:0]]; end
            KRamWr:    begin e_mem = 2; e_we = 1; end
            KUartRd:   begin e_mem = 3; e_rdn = 2; last_rd = {8'h00, uart_rx}; end
            KUartWr: begin
                tb_c  = (b_rise > 2) ? b_rise : 2;
                ts_c  = (s_rise > tb_c + 1) ? s_rise : tb_c + 1;
                e_mem = ts_c + 1;
                e_wrn = 1;
            end
            KStatRd: begin
                e_mem   = 2;
                last_rd = {14'b0, data_ready, (b_rise <= 1) && (s_rise <= 1)};
            end
            KStatWr:   e_mem = 2;
            KConflict: begin
                e_mem = 2; e_if = 5; e_oe = 2; last_rd = ref_mem[addr[14:0]];
            end
            default: ;
        endcase
        oe_cnt = 0; we_cnt = 0; rdn_cnt = 0; wrn_cnt = 0;
        tx_q.delete();
        Address   = addr;
        WriteData = wd;
        MemWrite  = want_mem && wr;
        MemRead   = want_mem && (!wr || ($urandom_range(0, 1) == 1));
        if_req    = want_if;
        if_addr   = iaddr;
        mem_lat = -1; if_lat = -1; stalls = 0;
        bus_at_ack = 16'h0000;
        max_cyc = (kind == KRam2) ? 5 : 200;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            tbre = (cyc >= b_rise);
            tsre = (cyc >= s_rise);
            @(negedge clk);
            if (stall) stalls++;
            if (mem_ack) begin
                if (mem_lat < 0) mem_lat = cyc;
                bus_at_ack = ram1_data;
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
            if (if_ack) begin
                if (if_lat < 0) if_lat = cyc;
                if_req = 1'b0;
            end
            @(posedge clk);
            #1;
            if (kind != KRam2 && (!want_mem || mem_lat >= 0) && (!want_if || if_lat >= 0)) break;
        end
        MemRead = 1'b0; MemWrite = 1'b0; if_req = 1'b0;
        check("mem_lat", mem_lat, e_mem);
        check("if_lat", if_lat, e_if);
        check("stall_cycles", stalls, (e_mem > 0) ? e_mem : 0);
        check("oe_low", oe_cnt, e_oe);
        check("we_low", we_cnt, e_we);
        check("rdn_low", rdn_cnt, e_rdn);
        check("wrn_low", wrn_cnt, e_wrn);
        check("rdata", ReadData, last_rd);
        if (want_if) check("if_data", if_data, ref_mem[iaddr[14:0]]);
        if (kind == KRamWr) begin
            check("bus_hold", bus_at_ack, wd);
            check("ram_cell", ram_mem[addr[14:0]], wd);
            ref_mem[addr[14:0]] = wd;
        end
        if (kind == KUartWr) begin
            check("tx_count", tx_q.size(), 1);
            check("tx_byte", (tx_q.size() > 0) ? tx_q[0] : 8'h00, wd[7:0]);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #1;
        check("rst_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
        check("rst_addr", ram1_addr, 18'h0);
        check("rst_ack", {mem_ack, if_ack}, 2'b00);
        MemRead = 1'b0; MemWrite = 1'b0; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        last_rd = 16'h0000;
        check("rst_rdata", ReadData, 16'h0000);
    endtask

    initial begin
        int          k, b, s;
        logic [15:0] a, ia;
        if_req = 0; MemRead = 0; MemWrite = 0; data_ready = 0; tbre = 0; tsre = 0;
        if_addr = 0; Address = 0; WriteData = 0; uart_rx = 0;
        oe_cnt = 0; we_cnt = 0; rdn_cnt = 0; wrn_cnt = 0;
        for (int i = 0; i < 32768; i++) begin
            ram_mem[i] = 16'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", {ram1_en, ram1_oe, ram1_we, rdn, wrn}, 5'b11111);
        check("reset_addr", ram1_addr, 18'h0);
        check("reset_rdata", ReadData, 16'h0);
        check("reset_ifdata", if_data, 16'h0);
        check("reset_acks", {mem_ack, if_ack, stall}, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        ram_mem[4] = 16'h6801; ref_mem[4] = 16'h6801;
        do_xact(KFetch, 16'h0000, 16'h0, 16'h0004, 0, 0);
        do_xact(KRamWr, 16'h4000, 16'hBEEF, 16'h0, 0, 0);
        do_xact(KConflict, 16'h0100, 16'h0, 16'h4000, 0, 0);
        uart_rx = 8'h41;
        do_xact(KUartRd, 16'hBF00, 16'h0, 16'h0, 0, 0);
        do_xact(KUartWr, 16'hBF00, 16'h1234, 16'h0, 4, 6);
        data_ready = 1'b1;
        do_xact(KStatRd, 16'hBF01, 16'h0, 16'h0, 0, 0);
        do_xact(KStatWr, 16'hBF01, 16'h5555, 16'h0, 0, 0);
        do_xact(KRamWr, 16'h7FFF, 16'h1357, 16'h0, 0, 0);
        do_xact(KRamRd, 16'h7FFF, 16'h0, 16'h0, 0, 0);
        do_xact(KRam2, 16'h8000, 16'h0, 16'h0, 0, 0);
        do_xact(KRam2, 16'hBF02, 16'h0, 16'h0, 0, 0);

        // Reset in the middle of a RAM write must release WE at once.
        Address = 16'h0123; WriteData = 16'hA5A5; MemWrite = 1'b1;
        @(posedge clk);
        #2;
        check("we_before_rst", ram1_we, 1'b0);
        reset_pulse();
        // Reset while waiting on the transmitter, then confirm both FSMs restart idle.
        Address = 16'hBF00; WriteData = 16'h00AA; MemWrite = 1'b1; tbre = 0; tsre = 0;
        repeat (3) @(posedge clk);
        #2;
        reset_pulse();
        do_xact(KRamRd, 16'h0004, 16'h0, 16'h0, 0, 0);
        uart_rx = 8'h7E;
        do_xact(KUartRd, 16'hBF00, 16'h0, 16'h0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            k  = $urandom_range(0, 8);
            a  = 16'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 16'h7FF0 : 16'h0);
            ia = 16'($urandom_range(0, 15));
            b  = 0; s = 0;
            uart_rx    = 8'($urandom);
            data_ready = 1'($urandom_range(0, 1));
            case (k)
                KUartRd, KUartWr: a = 16'hBF00;
                KStatRd, KStatWr: a = 16'hBF01;
                KRam2: a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h8000, 16'hBEFF))
                                                       : 16'($urandom_range(16'hBF02, 16'hFFFF));
                default: ;
            endcase
            if (k == KUartWr) begin
                b = $urandom_range(0, 6);
                s = $urandom_range(0, 10);
            end
            if (k == KStatRd) begin
                b = ($urandom_range(0, 1) == 1) ? 0 : 1000;
                s = ($urandom_range(0, 1) == 1) ? 0 : 1000;
            end
            do_xact(k, a, 16'($urandom), ia, b, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ram1_bus_arbiter.md
# ram1_bus_arbiter

Sequencer and arbiter for the shared RAM1/UART data bus. It grants the bus either to the instruction-fetch port or to the data-memory port, and runs the multi-cycle RAM1 and COM1 (UART) access sequences. It raises a stall to the pipeline while a data access owns the bus. It sits between the CPU pipeline and the board-level RAM1/UART pins; RAM2 accesses never pass through it.

## Interface
Parameters:
- RAM1_UPPER, 16'h8000, data addresses below this value map to RAM1
- COM1_DATA, 16'hBF00, UART data register
- COM1_COMMAND, 16'hBF01, UART status register

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  instruction fetch request
- if_addr  in  16  fetch address
- if_data  out  16  fetched word, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- MemRead, MemWrite  in  1 each  data request strobes, held until mem_ack
- Address  in  16  data address
- WriteData  in  16  store data
- ReadData  out  16  load data, valid while mem_ack=1, held afterwards
- mem_ack  out  1  one-cycle data completion pulse
- stall  out  1  pipeline freeze
- Ram1Data  inout  16  RAM1/UART shared data bus
- Ram1Addr  out  18  RAM1 address; bits [17:16] always 0
- Ram1EN, Ram1OE, Ram1WE  out  1 each  RAM1 strobes, active-low
- data_ready, tbre, tsre  in  1 each  UART status inputs
- rdn, wrn  out  1 each  UART strobes, active-low

## Operation
- Decode:
  - mem_sel = (MemRead|MemWrite) & (Address<RAM1_UPPER | Address==COM1_DATA | Address==COM1_COMMAND).
  - Requests outside these ranges belong to RAM2: no ack, no stall.
- Write priority: MemRead&MemWrite both high is treated as a write.
- Grant is evaluated only in IDLE:
  - a pending mem_sel always wins over if_req;
  - if_req is granted only when no mem_sel is pending.
- States:
  - IDLE
  - RAM_RD, RAM_WR
  - UART_RD1, UART_RD2
  - UART_WR, UART_WAIT_TBRE, UART_WAIT_TSRE
  - STAT_RD
  - DONE
- Transitions out of IDLE:
  - fetch, or data read below RAM1_UPPER → RAM_RD
  - data write below RAM1_UPPER → RAM_WR
  - COM1_DATA read → UART_RD1
  - COM1_DATA write → UART_WR
  - any COM1_COMMAND access → STAT_RD
- RAM_RD: Ram1EN=0, Ram1OE=0, address driven, bus high-Z; data captured at the end of the cycle → DONE.
- RAM_WR: Ram1EN=0, Ram1WE=0, Ram1OE=1, WriteData driven → DONE with Ram1WE=1. Data and address stay driven through DONE (hold time).
- UART_RD1 → UART_RD2: rdn=0 in both cycles. Ram1Data[7:0] is captured at the end of UART_RD2; ReadData={8'h00, byte} → DONE.
- UART write sequence:
  - UART_WR: wrn=0, {8'h00, WriteData[7:0]} driven.
  - UART_WAIT_TBRE: wrn=1; stays until tbre=1.
  - UART_WAIT_TSRE: stays until tsre=1 → DONE.
- STAT_RD:
  - read returns ReadData={14'b0, data_ready, tbre&tsre};
  - write is discarded;
  - → DONE.
- DONE:
  - all strobes high except the RAM_WR hold;
  - pulse if_ack or mem_ack for the granted port;
  - → IDLE.
- During UART states Ram1EN=1. Ram1Data is driven only in RAM_WR, DONE-after-RAM_WR and UART_WR; otherwise it is high-Z.
- stall = mem_sel & ~mem_ack. It is combinational, so it is high from the request cycle up to, but not including, the ack cycle.

## Timing
- Reset values:
  - state IDLE;
  - Ram1EN/OE/WE=1, rdn=wrn=1;
  - Ram1Addr=0, ReadData=0, if_data=0;
  - if_ack=mem_ack=0;
  - bus high-Z.
- Reset asserted mid-sequence deasserts every strobe immediately, asynchronously.
- RAM access: request seen in IDLE at edge E0, strobes active E0–E1, ack high E1–E2. Latency is 2 cycles; throughput is one access per 3 cycles.
- UART read latency is 3 cycles.
- UART write takes 3 cycles plus the tbre and tsre wait cycles; it has no timeout.
- A requester must drop its request in the ack cycle. A request still high in the cycle after DONE starts a new access.
- A fetch pending behind a data access waits and is re-arbitrated in the next IDLE.

## Structure
- Address constants and the NOP encoding belong in the shared define.v.
- State encodings are localparams inside this module.
- One sub-module, uart_seq, holds the UART_RD1..UART_WAIT_TSRE sequencing and the rdn/wrn generation. It has a start/done handshake with the top FSM.

## Test plan
- Fetch: if_req=1, if_addr=16'h0004, RAM returns 16'h6801 → if_ack in cycle 2, if_data=16'h6801; Ram1OE low for exactly one cycle.
- Data write: MemWrite, Address=16'h4000, WriteData=16'hBEEF → Ram1WE low for one cycle, bus=16'hBEEF through DONE; mem_ack in cycle 2; stall high for cycles 0–1.
- Conflict: if_req and MemRead at Address=16'h0100 in the same cycle → data served first (mem_ack at cycle 2); fetch acked at cycle 5.
- UART read: MemRead at 16'hBF00, bus low byte=8'h41 → rdn low 2 cycles; ReadData=16'h0041, mem_ack at cycle 3.
- UART write: MemWrite at 16'hBF00 with 16'h1234, tbre rises 4 cycles later, tsre 2 cycles after that → wrn low one cycle, bus low byte=8'h34; mem_ack only after tsre=1.
- Status and reset: MemRead at 16'hBF01 with data_ready=1, tbre=tsre=1 → ReadData=16'h0003. Separately, rst low during UART_WAIT_TBRE → all strobes high at once and state IDLE.
